// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Shares one combinational ALU between the main datapath (port 0)
//             and the branch/compare unit (port 1). Round-robin grant,
//             registered operands, one EXEC cycle, then a held response.
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int unsigned          WIDTH  = 32,
  parameter int unsigned          OPW    = 3,
  parameter logic [OPW-1:0]       NOP_OP = {OPW{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_srcb,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_srcb,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_less,
  output logic             rsp_equal,
  output logic             rsp_greater,
  output logic             rsp_overflow,

  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_srcb,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_less,
  input  logic             alu_equal,
  input  logic             alu_greater,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic             rr_ptr_q,   rr_ptr_d;
  logic             owner_q,    owner_d;
  logic [OPW-1:0]   op_q,       op_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [1:0]       srcb_q,     srcb_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       flags_q,    flags_d;   // {less, equal, greater, overflow}

  logic             grant0;
  logic             grant1;
  logic             owner_rsp_ready;

  // The owner's consume strobe; the other port's rsp_ready is ignored.
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state, grant and operand/result capture logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    srcb_d     = srcb_q;
    rsp_data_d = rsp_data_q;
    flags_d    = flags_q;
    grant0     = 1'b0;
    grant1     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A lone requester always wins; on contention rr_ptr picks.
        if (req0_valid && (!req1_valid || !rr_ptr_q)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end

        if (grant0) begin
          op_d    = req0_op;
          a_d     = req0_a;
          b_d     = req0_b;
          srcb_d  = req0_srcb;
          owner_d = 1'b0;
          state_d = ST_EXEC;
        end else if (grant1) begin
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          srcb_d  = req1_srcb;
          owner_d = 1'b1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        rsp_data_d = alu_out;
        flags_d    = {alu_less, alu_equal, alu_greater, alu_overflow};
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        // Hand priority to the other port once this response is taken.
        if (owner_rsp_ready) begin
          rr_ptr_d = ~owner_q;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= NOP_OP;
      a_q        <= '0;
      b_q        <= '0;
      srcb_q     <= '0;
      rsp_data_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      srcb_q     <= srcb_d;
      rsp_data_q <= rsp_data_d;
      flags_q    <= flags_d;
    end
  end

  // Ready is suppressed during reset since the state register may not be IDLE yet.
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;

  // The ALU sees the latched operation only during EXEC; otherwise a quiet NOP.
  always_comb begin
    alu_op   = NOP_OP;
    alu_a    = '0;
    alu_b    = '0;
    alu_srcb = '0;
    if (state_q == ST_EXEC) begin
      alu_op   = op_q;
      alu_a    = a_q;
      alu_b    = b_q;
      alu_srcb = srcb_q;
    end
  end

  assign rsp0_valid   = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid   = (state_q == ST_RESP) &&  owner_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_less     = flags_q[3];
  assign rsp_equal    = flags_q[2];
  assign rsp_greater  = flags_q[1];
  assign rsp_overflow = flags_q[0];

endmodule
`default_nettype wire
